// File: rtl/mmio_uart_tx_peripheral.sv
// Memory-mapped UART transmitter. It queues stored bytes in a TX FIFO and sends
// them as 8N1 frames on txd. Loads return the status and baud divisor registers.
//
// Bus handshake: single-cycle and always ready. The peripheral performs a store
// on every rising edge where sel && wmem. A load sees rdata in the same cycle as
// sel, with no wait states. When sel=0, rdata is 0.
module mmio_uart_tx_peripheral #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [63:0] wdata,
  input  logic        wmem,
  input  logic [2:0]  funct3,
  output logic [63:0] rdata,
  output logic        txd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic [15:0]   baud_div;

  logic [1:0]    state;
  logic [15:0]   bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic          full;
  logic          empty;
  logic          busy;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          bit_end;
  logic [3:0]    status_count;

  // Access size does not matter, and only the low bytes of a store are used.
  logic unused_bits;
  assign unused_bits = ^{funct3, wdata[63:16]};

  assign full         = (count == CW'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign busy         = (state != ST_IDLE);
  assign bit_end      = (bit_cnt == 16'd0);
  assign push         = sel && wmem && (addr == 4'h0);
  // A pop in the same cycle frees a slot, so a push while full is still taken.
  assign push_ok      = push && (!full || pop);
  // Pop when the serializer needs the next byte: from idle, or at the end of a stop bit.
  assign pop          = !empty && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
  assign status_count = 4'(count);

  // FIFO storage. Its contents are don't-care once the pointers reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop};
      if (push && !push_ok) begin
        ovf <= 1'b1;
      end else if (sel && wmem && (addr == 4'h4) && wdata[3]) begin
        ovf <= 1'b0;
      end
    end
  end

  // Baud divisor register. The serializer reads it only when a new bit starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_div <= DEFAULT_DIV;
    end else if (sel && wmem && (addr == 4'h8)) begin
      baud_div <= wdata[15:0];
    end
  end

  // Frame serializer. txd is registered and is set together with each state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      txd     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            bit_cnt <= baud_div;
            txd     <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            bit_cnt <= baud_div;
            bit_idx <= 3'd0;
            txd     <= shift[0];
            state   <= ST_DATA;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            bit_cnt <= baud_div;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: begin
          if (bit_end) begin
            if (pop) begin
              shift   <= mem[rd_ptr];
              bit_cnt <= baud_div;
              txd     <= 1'b0;
              state   <= ST_START;
            end else begin
              txd   <= 1'b1;
              state <= ST_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
      endcase
    end
  end

  // Load data decode. It is zero when the window is not selected.
  always_comb begin
    rdata = 64'd0;
    if (sel) begin
      case (addr)
        4'h4:    rdata = {56'd0, status_count, ovf, busy, empty, full};
        4'h8:    rdata = {48'd0, baud_div};
        default: rdata = 64'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx_peripheral.sv
// Testbench for mmio_uart_tx_peripheral. Stores queue expected frames: one byte
// plus the length of each of the ten bit positions. A txd monitor decodes every
// frame at cycle level and compares it with the queue head.
module tb_mmio_uart_tx_peripheral;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [3:0]  addr;
  logic [63:0] wdata;
  logic        wmem;
  logic [2:0]  funct3;
  logic [63:0] rdata;
  logic        txd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_frames = 0;
  int frames_done = 0;
  int frame_starts[$];

  logic [7:0]   exp_q[$];
  logic [159:0] per_q[$];

  mmio_uart_tx_peripheral #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd867)) dut (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr), .wdata(wdata),
    .wmem(wmem), .funct3(funct3), .rdata(rdata), .txd(txd)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [159:0] uniform_per(input int p);
    logic [159:0] r;
    for (int i = 0; i < 10; i++) r[i*16 +: 16] = 16'(p);
    return r;
  endfunction

  function automatic logic [63:0] status_word(input int cnt, input bit o, input bit b);
    return {56'd0, 4'(cnt), o, b, (cnt == 0), (cnt == DEPTH)};
  endfunction

  // Driver tasks. They are called at a negedge and return at a later negedge.
  task automatic bus_write(input logic [3:0] a, input logic [63:0] d);
    sel = 1'b1; wmem = 1'b1; addr = a; wdata = d; funct3 = 3'($urandom_range(0, 3));
    @(negedge clk);
    sel = 1'b0; wmem = 1'b0; addr = 4'h0; wdata = 64'd0;
  endtask

  task automatic store_byte(input logic [7:0] b, input logic [159:0] per);
    exp_q.push_back(b);
    per_q.push_back(per);
    bus_write(4'h0, {$urandom, $urandom_range(0, 16777215), b});
  endtask

  task automatic check_read(input logic [3:0] a, input logic [63:0] exp, input string name);
    sel = 1'b1; wmem = 1'b0; addr = a;
    #1;
    checks++;
    if (rdata !== exp) begin
      errors++;
      $display("FAIL %s: rdata=0x%0h required 0x%0h", name, rdata, exp);
    end
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frames_done < target) begin
      errors++;
      $display("FAIL %s timeout: frames_done=%0d required %0d", name, frames_done, target);
    end
    @(negedge clk);
  endtask

  task automatic wait_start(input int prev, output int start);
    int n;
    n = 0;
    while (n_frames <= prev && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n_frames <= prev) begin
      errors++;
      $display("FAIL frame_start timeout: n_frames=%0d required >%0d", n_frames, prev);
      start = cyc;
    end else begin
      start = frame_starts[prev];
    end
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: detects a start bit, pops the expected frame and checks every cycle of it.
  initial begin : monitor
    logic         prev;
    logic [7:0]   b;
    logic [159:0] p;
    logic [9:0]   fr;
    int           bad;
    int           first_pos;
    bit           abort;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
      end else if (prev && !txd) begin
        frame_starts.push_back(cyc);
        n_frames++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: start bit at cycle %0d with no byte queued", cyc);
          prev = txd;
        end else begin
          b = exp_q.pop_front();
          p = per_q.pop_front();
          fr = {1'b1, b, 1'b0};
          bad = 0;
          first_pos = -1;
          abort = 1'b0;
          for (int pos = 0; pos < 10 && !abort; pos++) begin
            for (int j = 0; j < int'(p[pos*16 +: 16]) && !abort; j++) begin
              if (!(pos == 0 && j == 0)) begin
                @(negedge clk);
                if (rst) abort = 1'b1;
              end
              if (!abort && txd !== fr[pos]) begin
                bad++;
                if (first_pos < 0) first_pos = pos;
              end
            end
          end
          if (!abort) begin
            checks++;
            if (bad != 0) begin
              errors++;
              $display("FAIL frame 0x%02h: %0d wrong txd cycles, first at bit position %0d, required waveform 0b%010b (LSB first)",
                       b, bad, first_pos, fr);
            end
            frames_done++;
          end
          prev = rst ? 1'b1 : txd;
        end
      end else begin
        prev = txd;
      end
    end
  end

  // Stimulus.
  initial begin : stimulus
    int start;
    int nf;
    int base;
    int d;
    int n;
    logic [7:0] bv;
    rst = 1'b1; sel = 1'b0; addr = 4'h0; wdata = 64'd0; wmem = 1'b0; funct3 = 3'd0;
    repeat (3) @(negedge clk);
    check_val("reset_txd", int'(txd), 1);
    rst = 1'b0;

    // Reset state.
    check_read(4'h4, status_word(0, 0, 0), "reset_status");
    check_read(4'h8, 64'd867, "reset_bauddiv");
    check_val("idle_txd", int'(txd), 1);
    sel = 1'b0; addr = 4'h4; #1;
    check_val("unselected_rdata_zero", int'(rdata[31:0]), 0);
    @(negedge clk);
    check_read(4'hC, 64'd0, "unmapped_offset");

    // Single frame 0xA5 with 4-cycle bits.
    bus_write(4'h8, 64'd3);
    check_read(4'h8, 64'd3, "bauddiv_write");
    nf = n_frames;
    base = frames_done;
    store_byte(8'hA5, uniform_per(4));
    wait_start(nf, start);
    wait_cycle(start + 5);
    check_read(4'h4, status_word(0, 0, 1), "busy_during_frame");
    wait_frames(base + 1, 200, "frame_a5");
    check_read(4'h4, status_word(0, 0, 0), "idle_after_frame");

    // Fill the FIFO, overflow it, then clear ovf.
    base = frames_done;
    for (int i = 0; i < DEPTH + 1; i++) store_byte(8'($urandom), uniform_per(4));
    check_read(4'h4, status_word(DEPTH, 0, 1), "fifo_full_no_ovf");
    bus_write(4'h0, 64'h5A);
    check_read(4'h4, status_word(DEPTH, 1, 1), "ovf_set_on_drop");
    bus_write(4'h4, 64'h8);
    check_read(4'h4, status_word(DEPTH, 0, 1), "ovf_cleared");
    wait_frames(base + DEPTH + 1, 600, "fifo_drain");
    check_read(4'h4, status_word(0, 0, 0), "idle_after_drain");

    // Back-to-back frames, with no idle cycle between stop and start.
    base = frames_done;
    nf = n_frames;
    store_byte(8'h00, uniform_per(4));
    store_byte(8'hFF, uniform_per(4));
    wait_frames(base + 2, 200, "back_to_back");
    check_val("back_to_back_gap", frame_starts[nf + 1] - frame_starts[nf], 40);

    // Reset in the middle of a frame, with a second byte still queued.
    nf = n_frames;
    store_byte($urandom_range(0, 255), uniform_per(4));
    store_byte($urandom_range(0, 255), uniform_per(4));
    wait_start(nf, start);
    wait_cycle(start + 15);
    rst = 1'b1;
    exp_q.delete();
    per_q.delete();
    @(posedge clk);
    #1;
    check_val("txd_high_after_rst", int'(txd), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_read(4'h4, status_word(0, 0, 0), "flushed_after_rst");
    check_read(4'h8, 64'd867, "bauddiv_after_rst");
    nf = n_frames;
    sel = 1'b0; wmem = 1'b1; addr = 4'h0; wdata = 64'h55;
    @(negedge clk);
    wmem = 1'b0; wdata = 64'd0;
    repeat (100) @(negedge clk);
    check_val("no_frame_after_rst_or_unselected_store", n_frames, nf);

    // Divisor change during bit 3: bit 3 keeps 4 cycles, later bits take 2.
    bus_write(4'h8, 64'd3);
    nf = n_frames;
    base = frames_done;
    bv = 8'($urandom);
    store_byte(bv, {{5{16'd2}}, {5{16'd4}}});
    wait_start(nf, start);
    wait_cycle(start + 17);
    bus_write(4'h8, 64'd1);
    wait_frames(base + 1, 200, "mid_frame_div");
    check_read(4'h8, 64'd1, "bauddiv_after_change");

    // Random bursts with random divisors, including 1-cycle bits.
    for (int k = 0; k < 6; k++) begin
      d = (k == 0) ? 0 : $urandom_range(0, 5);
      bus_write(4'h8, 64'(d));
      n = $urandom_range(1, DEPTH + 1);
      base = frames_done;
      for (int i = 0; i < n; i++) begin
        store_byte(8'($urandom), uniform_per(d + 1));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_frames(base + n, n * 10 * (d + 1) + 100, "random_burst");
      check_read(4'h4, status_word(0, 0, 0), "idle_after_burst");
    end

    check_val("queue_empty_at_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
